// File: rtl/hook_ctrl.sv
// hook_ctrl: per-player claw controller. It swings the angle, fires, extends the line,
// retracts it and drives the tail position. Dynamite logic is built only with HOOK_DYNAMITE_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | hook swings between angle 0 and 10 and waits for fire
// S_EXTEND  | line grows one step per fast tick until catch, max or edge
// S_RETRACT | line shrinks; slow tick when loaded, fast tick when empty

module hook_ctrl #(
   parameter int PIVOT_X    = 430,
   parameter int PIVOT_Y    = 70,
   parameter int TICK       = 2000000,
   parameter int SWING_TICK = 4000000,
   parameter int MAX_STEPS  = 80,
   parameter int DYN_INIT   = 2
) (
   input  logic       Clk,
   input  logic       reset_n,
   input  logic       is_new_game_start,
   input  logic       fire,
   input  logic       catch_any,
   input  logic       dyn_key,
   input  logic       add_dynamite,
   output logic [9:0] tailx,
   output logic [9:0] taily,
   output logic [3:0] R_mode,
   output logic [2:0] state_out,
   output logic       is_explode,
   output logic [2:0] dyn_count
);

   localparam int CMAX = (TICK > SWING_TICK) ? TICK : SWING_TICK;
   localparam int PW   = $clog2(CMAX + 1);
   localparam int NW   = $clog2(MAX_STEPS + 2);

   localparam logic [PW-1:0]      SWING_CMP = PW'(SWING_TICK);
   localparam logic [PW-1:0]      SLOW_CMP  = PW'(TICK);
   localparam logic [PW-1:0]      FAST_CMP  = PW'(TICK / 4);
   localparam logic [NW-1:0]      MAX_N     = NW'(MAX_STEPS);
   localparam logic signed [10:0] PX        = 11'(PIVOT_X);
   localparam logic signed [10:0] PY        = 11'(PIVOT_Y);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXTEND  = 2'd1,
      S_RETRACT = 2'd2
   } state_t;

   state_t            state, state_d;
   logic [3:0]        k, k_d;
   logic              up, up_d;
   logic [NW-1:0]     n, n_d;
   logic [PW-1:0]     pre, pre_d;
   logic              loaded, loaded_d;

   logic signed [10:0] dx, dy;
   logic signed [10:0] n_s, n1_s;
   logic signed [10:0] cur_x, cur_y, nxt_x, nxt_y;
   logic               clear;
   logic               out_of_bounds;
   logic               dyn_use;

   assign clear = !reset_n || is_new_game_start;

   always_comb begin
      dx = 11'sd0;
      dy = 11'sd0;
      case (k)
         4'd0:    begin dx = -11'sd6; dy = 11'sd0; end
         4'd1:    begin dx = -11'sd6; dy = 11'sd1; end
         4'd2:    begin dx = -11'sd5; dy = 11'sd2; end
         4'd3:    begin dx = -11'sd4; dy = 11'sd3; end
         4'd4:    begin dx = -11'sd2; dy = 11'sd4; end
         4'd5:    begin dx = 11'sd0;  dy = 11'sd6; end
         4'd6:    begin dx = 11'sd2;  dy = 11'sd4; end
         4'd7:    begin dx = 11'sd4;  dy = 11'sd3; end
         4'd8:    begin dx = 11'sd5;  dy = 11'sd2; end
         4'd9:    begin dx = 11'sd6;  dy = 11'sd1; end
         4'd10:   begin dx = 11'sd6;  dy = 11'sd0; end
         default: begin dx = 11'sd0;  dy = 11'sd0; end
      endcase
   end

   // Tail of the current step and of the one after it; the latter gates the screen edge.
   assign n_s   = signed'(11'(n));
   assign n1_s  = n_s + 11'sd1;
   assign cur_x = PX + n_s * dx;
   assign cur_y = PY + n_s * dy;
   assign nxt_x = PX + n1_s * dx;
   assign nxt_y = PY + n1_s * dy;

   assign out_of_bounds = (nxt_x < 11'sd8) || (nxt_x > 11'sd631) || (nxt_y > 11'sd471);

`ifdef HOOK_DYNAMITE_EN
   logic [2:0] dyn_q;
   logic       explode_q;

   assign dyn_use = (state == S_RETRACT) && (n != '0) && loaded && dyn_key && (dyn_q != 3'd0);

   always_ff @(posedge Clk) begin
      if (clear) begin
         dyn_q     <= 3'(DYN_INIT);
         explode_q <= 1'b0;
      end else begin
         explode_q <= dyn_use;
         if (dyn_use && !add_dynamite)
            dyn_q <= dyn_q - 3'd1;
         else if (add_dynamite && !dyn_use && dyn_q != 3'd7)
            dyn_q <= dyn_q + 3'd1;
      end
   end

   assign dyn_count  = dyn_q;
   assign is_explode = explode_q;
`else
   logic [2:0] unused_dyn;

   assign unused_dyn = 3'(DYN_INIT) ^ {1'b0, dyn_key, add_dynamite};
   assign dyn_use    = 1'b0;
   assign dyn_count  = 3'd0;
   assign is_explode = 1'b0;
`endif

   always_comb begin
      state_d  = state;
      k_d      = k;
      up_d     = up;
      n_d      = n;
      pre_d    = pre + PW'(1);
      loaded_d = loaded;
      case (state)
         S_IDLE: begin
            // Fire wins over a same-cycle swing step so the latched angle is the one shown.
            if (fire) begin
               state_d  = S_EXTEND;
               pre_d    = '0;
               loaded_d = 1'b0;
            end else if (pre == SWING_CMP) begin
               pre_d = '0;
               if (up) begin
                  if (k >= 4'd10) begin
                     k_d  = 4'd9;
                     up_d = 1'b0;
                  end else begin
                     k_d = k + 4'd1;
                  end
               end else begin
                  if (k == 4'd0) begin
                     k_d  = 4'd1;
                     up_d = 1'b1;
                  end else begin
                     k_d = k - 4'd1;
                  end
               end
            end
         end
         S_EXTEND: begin
            if (catch_any || (n == MAX_N) || out_of_bounds) begin
               state_d  = S_RETRACT;
               pre_d    = '0;
               loaded_d = catch_any;
            end else if (pre == FAST_CMP) begin
               pre_d = '0;
               n_d   = n + NW'(1);
            end
         end
         S_RETRACT: begin
            if (n == '0) begin
               state_d = S_IDLE;
               pre_d   = '0;
            end else if (dyn_use) begin
               loaded_d = 1'b0;
               pre_d    = '0;
            end else if (pre == (loaded ? SLOW_CMP : FAST_CMP)) begin
               pre_d = '0;
               n_d   = n - NW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            pre_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (clear) begin
         state  <= S_IDLE;
         k      <= 4'd5;
         up     <= 1'b1;
         n      <= '0;
         pre    <= '0;
         loaded <= 1'b0;
         tailx  <= PX[9:0];
         taily  <= PY[9:0];
      end else begin
         state  <= state_d;
         k      <= k_d;
         up     <= up_d;
         n      <= n_d;
         pre    <= pre_d;
         loaded <= loaded_d;
         tailx  <= cur_x[9:0];
         taily  <= cur_y[9:0];
      end
   end

   assign R_mode    = k;
   assign state_out = {1'b0, state};

endmodule

// File: tb/tb_hook_ctrl.sv
// Self-checking bench for hook_ctrl: two instances (pivot x 430 and 40) share stimulus and are
// compared every cycle against a rule-level model; directed phases pin the model with literals.

module tb_hook_ctrl;

   localparam int TICK       = 8;
   localparam int SWING_TICK = 4;
   localparam int MAX_STEPS  = 10;
   localparam int DYN_INIT   = 2;
   localparam int PXA        = 430;
   localparam int PXB        = 40;
   localparam int PY         = 70;
`ifdef HOOK_DYNAMITE_EN
   localparam int DYN_EN = 1;
`else
   localparam int DYN_EN = 0;
`endif

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic       reset_n, is_new_game_start, fire, catch_any, dyn_key, add_dynamite;
   logic [9:0] tx_a, ty_a, tx_b, ty_b;
   logic [3:0] rm_a, rm_b;
   logic [2:0] st_a, st_b, dc_a, dc_b;
   logic       ex_a, ex_b;

   hook_ctrl #(.PIVOT_X(PXA), .PIVOT_Y(PY), .TICK(TICK), .SWING_TICK(SWING_TICK),
               .MAX_STEPS(MAX_STEPS), .DYN_INIT(DYN_INIT)) dut_a (
      .Clk(Clk), .reset_n(reset_n), .is_new_game_start(is_new_game_start), .fire(fire),
      .catch_any(catch_any), .dyn_key(dyn_key), .add_dynamite(add_dynamite),
      .tailx(tx_a), .taily(ty_a), .R_mode(rm_a), .state_out(st_a),
      .is_explode(ex_a), .dyn_count(dc_a));

   hook_ctrl #(.PIVOT_X(PXB), .PIVOT_Y(PY), .TICK(TICK), .SWING_TICK(SWING_TICK),
               .MAX_STEPS(MAX_STEPS), .DYN_INIT(DYN_INIT)) dut_b (
      .Clk(Clk), .reset_n(reset_n), .is_new_game_start(is_new_game_start), .fire(fire),
      .catch_any(catch_any), .dyn_key(dyn_key), .add_dynamite(add_dynamite),
      .tailx(tx_b), .taily(ty_b), .R_mode(rm_b), .state_out(st_b),
      .is_explode(ex_b), .dyn_count(dc_b));

   // Model: the swing is a phase 0..19 folded into a triangle wave, so bounces fall out naturally.
   typedef struct packed {
      int mode;
      int ph;
      int n;
      int pre;
      int ld;
      int dyn;
      int ex;
      int tx;
      int ty;
   } ms_t;

   ms_t ma, mb;
   int  checks = 0;
   int  errors = 0;
   bit  chk_en = 1'b0;

   function automatic int angle(int ph);
      return (ph <= 10) ? ph : 20 - ph;
   endfunction

   function automatic int dxv(int k);
      case (k)
         0: return -6;  1: return -6;  2: return -5;  3: return -4;
         4: return -2;  5: return 0;   6: return 2;   7: return 4;
         8: return 5;   9: return 6;   10: return 6;
         default: return 0;
      endcase
   endfunction

   function automatic int dyv(int k);
      case (k)
         0: return 0;  1: return 1;  2: return 2;  3: return 3;
         4: return 4;  5: return 6;  6: return 4;  7: return 3;
         8: return 2;  9: return 1;  10: return 0;
         default: return 0;
      endcase
   endfunction

   function automatic ms_t mreset(int px);
      ms_t r;
      r.mode = 0; r.ph = 5; r.n = 0; r.pre = 0; r.ld = 0;
      r.dyn  = DYN_EN ? DYN_INIT : 0;
      r.ex   = 0; r.tx = px; r.ty = PY;
      return r;
   endfunction

   function automatic ms_t mnext(ms_t s, int px, bit rst, bit f, bit c, bit dk, bit ad);
      ms_t r;
      int  k, nx, ny, lim;
      bit  use_dyn;
      if (rst) return mreset(px);
      r = s;
      k = angle(s.ph);
      use_dyn = 1'b0;
      r.tx = px + s.n * dxv(k);
      r.ty = PY + s.n * dyv(k);
      case (s.mode)
         0: begin
            if (f) begin
               r.mode = 1; r.pre = 0; r.ld = 0;
            end else if (s.pre == SWING_TICK) begin
               r.pre = 0; r.ph = (s.ph + 1) % 20;
            end else r.pre = s.pre + 1;
         end
         1: begin
            nx = px + (s.n + 1) * dxv(k);
            ny = PY + (s.n + 1) * dyv(k);
            if (c || s.n == MAX_STEPS || nx < 8 || nx > 631 || ny > 471) begin
               r.mode = 2; r.pre = 0; r.ld = c ? 1 : 0;
            end else if (s.pre == TICK / 4) begin
               r.pre = 0; r.n = s.n + 1;
            end else r.pre = s.pre + 1;
         end
         default: begin
            if (s.n == 0) begin
               r.mode = 0; r.pre = 0;
            end else if (DYN_EN != 0 && s.ld != 0 && dk && s.dyn > 0) begin
               use_dyn = 1'b1; r.ld = 0; r.pre = 0;
            end else begin
               lim = (s.ld != 0) ? TICK : TICK / 4;
               if (s.pre == lim) begin
                  r.pre = 0; r.n = s.n - 1;
               end else r.pre = s.pre + 1;
            end
         end
      endcase
      if (DYN_EN != 0) begin
         r.dyn = s.dyn - (use_dyn ? 1 : 0) + (ad ? 1 : 0);
         if (r.dyn > 7) r.dyn = 7;
         r.ex = use_dyn ? 1 : 0;
      end
      return r;
   endfunction

   always @(posedge Clk) begin
      ma <= mnext(ma, PXA, !reset_n || is_new_game_start, fire, catch_any, dyn_key, add_dynamite);
      mb <= mnext(mb, PXB, !reset_n || is_new_game_start, fire, catch_any, dyn_key, add_dynamite);
   end

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (chk_en) begin
         check("a_tailx", int'(tx_a), ma.tx & 1023);
         check("a_taily", int'(ty_a), ma.ty & 1023);
         check("a_rmode", int'(rm_a), angle(ma.ph));
         check("a_state", int'(st_a), ma.mode);
         check("a_explode", int'(ex_a), ma.ex);
         check("a_dyn", int'(dc_a), ma.dyn);
         check("b_tailx", int'(tx_b), mb.tx & 1023);
         check("b_taily", int'(ty_b), mb.ty & 1023);
         check("b_rmode", int'(rm_b), angle(mb.ph));
         check("b_state", int'(st_b), mb.mode);
         check("b_explode", int'(ex_b), mb.ex);
         check("b_dyn", int'(dc_b), mb.dyn);
      end
   end

   task automatic wait_rmode(input int v, input int bound);
      for (int i = 0; i < bound && int'(rm_a) != v; i++) @(negedge Clk);
      check("wait_rmode", int'(rm_a), v);
   endtask

   task automatic wait_idle(input int bound, output int ret_b);
      ret_b = 0;
      for (int i = 0; i < bound && (st_a != 3'd0 || st_b != 3'd0); i++) begin
         @(negedge Clk);
         if (st_b == 3'd2) ret_b++;
      end
      check("wait_idle_a", int'(st_a), 0);
      check("wait_idle_b", int'(st_b), 0);
   endtask

   task automatic fire_and_run(input int catch_at, input int bound, output int ext,
                               output int ret, output int expl, output int ty_ret1,
                               output int tx_catch);
      ext = 0; ret = 0; expl = 0; ty_ret1 = -1; tx_catch = -1;
      fire = 1'b1;
      for (int i = 0; i < bound; i++) begin
         @(negedge Clk);
         fire = 1'b0;
         if (st_a == 3'd1) ext++;
         if (st_a == 3'd2) begin
            ret++;
            if (ret == 1) ty_ret1 = int'(ty_a);
         end
         if (ex_a) expl++;
         catch_any = (catch_at > 0) && (ext == catch_at) && (st_a == 3'd1);
         if (catch_any) tx_catch = int'(tx_a);
         if (st_a == 3'd0 && st_b == 3'd0) break;
      end
      catch_any = 1'b0;
      check("run_idle_a", int'(st_a), 0);
      check("run_idle_b", int'(st_b), 0);
   endtask

   int ext, ret, expl, ty1, txc, retb;

   initial begin
      reset_n = 1'b0; is_new_game_start = 1'b0; fire = 1'b0; catch_any = 1'b0;
      dyn_key = 1'b0; add_dynamite = 1'b0;
      repeat (3) @(negedge Clk);
      chk_en = 1'b1;
      check("rst_tailx", int'(tx_a), 430);
      check("rst_taily", int'(ty_a), 70);
      check("rst_rmode", int'(rm_a), 5);
      check("rst_state", int'(st_a), 0);
      check("rst_dyn", int'(dc_a), DYN_EN ? DYN_INIT : 0);
      reset_n = 1'b1;

      // Swing: 6 steps in 30 cycles gives 6,7,8,9,10,9
      repeat (30) @(negedge Clk);
      check("swing_rmode_30", int'(rm_a), 9);
      check("swing_tailx", int'(tx_a), 430);

      // Empty full-length shot straight down
      wait_rmode(5, 100);
      fire_and_run(0, 300, ext, ret, expl, ty1, txc);
      check("t2_ext_cycles", ext, (TICK / 4 + 1) * MAX_STEPS + 1);
      check("t2_ret_cycles", ret, (TICK / 4 + 1) * MAX_STEPS + 1);
      check("t2_taily_max", ty1, 130);
      check("t2_home_x", int'(tx_a), 430);
      check("t2_home_y", int'(ty_a), 70);

      // Catch at n=3 to the right, loaded retract
      wait_rmode(10, 200);
      fire_and_run(11, 300, ext, ret, expl, ty1, txc);
      check("t3_catch_x", txc, 448);
      check("t3_ret_cycles", ret, 3 * (TICK + 1) + 1);

      // Loaded retract with dynamite key held
      wait_rmode(7, 200);
      dyn_key = 1'b1;
      fire_and_run(8, 300, ext, ret, expl, ty1, txc);
      dyn_key = 1'b0;
      check("t4_explode_pulses", expl, DYN_EN);
      check("t4_dyn_left", int'(dc_a), DYN_EN ? 1 : 0);
      check("t4_ret_cycles", ret, DYN_EN ? 2 * (TICK / 4 + 1) + 2 : 2 * (TICK + 1) + 1);

      // Saturation of the dynamite count
      repeat (8) begin
         add_dynamite = 1'b1;
         @(negedge Clk);
      end
      add_dynamite = 1'b0;
      check("sat_dyn", int'(dc_a), DYN_EN ? 7 : 0);

      // Left edge on pivot 40 at n=5, catch in the same cycle
      wait_rmode(0, 200);
      fire = 1'b1;
      @(negedge Clk);
      fire = 1'b0;
      repeat (15) @(negedge Clk);
      check("t5_b_still_ext", int'(st_b), 1);
      catch_any = 1'b1;
      @(negedge Clk);
      catch_any = 1'b0;
      check("t5_b_retract", int'(st_b), 2);
      @(negedge Clk);
      check("t5_b_tailx", int'(tx_b), 10);
      wait_idle(200, retb);
      check("t5_b_loaded_ret", retb + 2, 5 * (TICK + 1) + 1);

      // Reset mid-extend
      fire = 1'b1;
      @(negedge Clk);
      fire = 1'b0;
      repeat (12) @(negedge Clk);
      check("t6_extending", int'(st_a), 1);
      reset_n = 1'b0;
      @(negedge Clk);
      reset_n = 1'b1;
      check("t6_state", int'(st_a), 0);
      check("t6_tailx", int'(tx_a), 430);
      check("t6_taily", int'(ty_a), 70);
      check("t6_rmode", int'(rm_a), 5);
      check("t6_dyn", int'(dc_a), DYN_EN ? DYN_INIT : 0);

      // New-game clear mid-extend
      fire = 1'b1;
      @(negedge Clk);
      fire = 1'b0;
      repeat (5) @(negedge Clk);
      is_new_game_start = 1'b1;
      @(negedge Clk);
      is_new_game_start = 1'b0;
      check("ngs_state", int'(st_a), 0);
      check("ngs_rmode", int'(rm_a), 5);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         fire              = ($urandom_range(0, 7) == 0);
         catch_any         = ($urandom_range(0, 15) == 0);
         dyn_key           = ($urandom_range(0, 3) == 0);
         add_dynamite      = ($urandom_range(0, 9) == 0);
         reset_n           = ($urandom_range(0, 699) != 0);
         is_new_game_start = ($urandom_range(0, 899) == 0);
         @(negedge Clk);
      end
      fire = 1'b0; catch_any = 1'b0; dyn_key = 1'b0; add_dynamite = 1'b0;
      reset_n = 1'b1; is_new_game_start = 1'b0;
      repeat (2) @(negedge Clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
